// File: rtl/circ_fifo_param.sv
// Parametrised circular-buffer FIFO: registered read data with valid strobe,
// optional overwrite-oldest, occupancy flags, overflow/underflow pulses and sticky error.
module circ_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int OVERWRITE = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             rd_acc, wr_ok, ovw, wr_mem, ovf_n, udf_n;

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read freeing a slot lets a write into a full FIFO in the same cycle.
  assign rd_acc = !clear && rd_en && !fifo_empty;
  assign wr_ok  = !clear && wr_en && (!fifo_full || rd_acc);
  assign ovf_n  = !clear && wr_en && fifo_full && !rd_acc;
  assign ovw    = (OVERWRITE != 0) && ovf_n;
  assign wr_mem = wr_ok || ovw;
  assign udf_n  = !clear && rd_en && fifo_empty;

  always_ff @(posedge CLK) begin
    if (wr_mem) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      error     <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      error     <= 1'b0;
    end else begin
      rd_valid  <= rd_acc;
      overflow  <= ovf_n;
      underflow <= udf_n;
      if (rd_acc) rd_data <= mem[rd_ptr];
      // Overwrite drops the oldest entry, so the read pointer moves with the write.
      if (rd_acc || ovw) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_mem) wr_ptr <= ptr_inc(wr_ptr);
      unique case ({wr_ok, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (udf_n || (ovf_n && (OVERWRITE == 0))) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_circ_fifo_param.sv
// Bench for circ_fifo_param: three configurations (8 deep drop, 5 deep with custom
// thresholds, 8 deep overwrite) checked every cycle against a queue-based model.
module tb_circ_fifo_param;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic [2:0]      clr = '0, wr_en = '0, rd_en = '0;
  logic [2:0][7:0] wr_data = '0;
  logic [2:0][7:0] rd_data;
  logic [2:0]      rd_valid, f_empty, f_full, a_full, a_empty, ovf, udf, err;
  logic [3:0]      cnt [3];
  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  function automatic int dep(input int k); return (k == 1) ? 5 : 8; endfunction
  function automatic bit ow(input int k);  return (k == 2); endfunction
  function automatic int af(input int k);  return (k == 1) ? 3 : dep(k) - 1; endfunction
  function automatic int ae(input int k);  return (k == 1) ? 2 : 1; endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int D  = (k == 1) ? 5 : 8;
    localparam int OW = (k == 2) ? 1 : 0;
    localparam int AF = (k == 1) ? 3 : D - 1;
    localparam int AE = (k == 1) ? 2 : 1;
    logic [$clog2(D+1)-1:0] c;
    circ_fifo_param #(.WIDTH(8), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .OVERWRITE(OW)) u_dut (
      .CLK(CLK), .RESET(RESET), .clear(clr[k]), .wr_en(wr_en[k]), .wr_data(wr_data[k]),
      .rd_en(rd_en[k]), .rd_data(rd_data[k]), .rd_valid(rd_valid[k]),
      .fifo_empty(f_empty[k]), .fifo_full(f_full[k]), .almost_full(a_full[k]),
      .almost_empty(a_empty[k]), .count(c), .overflow(ovf[k]), .underflow(udf[k]),
      .error(err[k]));
    assign cnt[k] = 4'(c);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, everything else follows from its size.
  logic [7:0] mq [3][$];
  logic [7:0] m_rd [3] = '{default: 8'h00};
  bit m_rv [3] = '{default: 1'b0};
  bit m_ov [3] = '{default: 1'b0};
  bit m_un [3] = '{default: 1'b0};
  bit m_err [3] = '{default: 1'b0};

  always @(posedge CLK or negedge RESET) begin
    for (int k = 0; k < 3; k++) begin
      int n;
      bit rd, full;
      n = mq[k].size();
      if (!RESET) begin
        mq[k].delete();
        m_rd[k] = 8'h00; m_rv[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_err[k] = 0;
      end else if (clr[k]) begin
        mq[k].delete();
        m_rv[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_err[k] = 0;
      end else begin
        full    = (n == dep(k));
        rd      = rd_en[k] && (n > 0);
        m_un[k] = rd_en[k] && (n == 0);
        m_ov[k] = wr_en[k] && full && !rd;
        m_rv[k] = rd;
        if (rd) m_rd[k] = mq[k].pop_front();
        if (wr_en[k]) begin
          if (!full || rd) mq[k].push_back(wr_data[k]);
          else if (ow(k)) begin
            void'(mq[k].pop_front());
            mq[k].push_back(wr_data[k]);
          end
        end
        if (m_un[k] || (m_ov[k] && !ow(k))) m_err[k] = 1;
      end
    end
  end

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      int n;
      n = mq[k].size();
      chk($sformatf("k%0d count", k), cnt[k], n);
      chk($sformatf("k%0d empty", k), f_empty[k], n == 0);
      chk($sformatf("k%0d full", k), f_full[k], n == dep(k));
      chk($sformatf("k%0d almost_full", k), a_full[k], n >= af(k));
      chk($sformatf("k%0d almost_empty", k), a_empty[k], n <= ae(k));
      chk($sformatf("k%0d rd_data", k), rd_data[k], m_rd[k]);
      chk($sformatf("k%0d rd_valid", k), rd_valid[k], m_rv[k]);
      chk($sformatf("k%0d overflow", k), ovf[k], m_ov[k]);
      chk($sformatf("k%0d underflow", k), udf[k], m_un[k]);
      chk($sformatf("k%0d error", k), err[k], m_err[k]);
    end
  end

  task automatic idle();
    clr = '0; wr_en = '0; rd_en = '0;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    int wp, rp;
    RESET = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      chk("reset count", cnt[k], 0);
      chk("reset empty", f_empty[k], 1);
      chk("reset rd_data", rd_data[k], 0);
      chk("reset error", err[k], 0);
    end
    RESET = 1'b1;
    step();

    // Fill k0 with 0x10..0x17 and k2 with 0..7.
    for (int i = 0; i < 8; i++) begin
      wr_en = 3'b101; wr_data[0] = 8'h10 + 8'(i); wr_data[2] = 8'(i);
      step();
      if (i == 5) chk("af before 7th", a_full[0], 0);
      if (i == 6) chk("af after 7th", a_full[0], 1);
    end
    idle();
    chk("k0 full", f_full[0], 1);
    chk("k0 count 8", cnt[0], 8);

    wr_en = 3'b101; wr_data[0] = 8'hAA; wr_data[2] = 8'hEE;
    step(); idle();
    chk("k0 overflow", ovf[0], 1);
    chk("k0 error", err[0], 1);
    chk("k0 count ovf", cnt[0], 8);
    chk("k2 overflow", ovf[2], 1);
    chk("k2 error", err[2], 0);
    chk("k2 count ovw", cnt[2], 8);
    step();
    chk("k0 ovf pulse end", ovf[0], 0);

    for (int i = 0; i < 8; i++) begin
      rd_en = 3'b101;
      step();
      chk("k0 rd_valid", rd_valid[0], 1);
      chk("k0 order", rd_data[0], 8'h10 + 8'(i));
      chk("k2 order", rd_data[2], (i < 7) ? i + 1 : 8'hEE);
    end
    idle(); step();
    chk("k0 drained", f_empty[0], 1);
    chk("k0 rv drop", rd_valid[0], 0);

    clr[0] = 1'b1; step(); idle();
    chk("k0 clear err", err[0], 0);
    chk("k0 clear cnt", cnt[0], 0);

    // Depth-5 wrap: write 5, read 3, write 3, read 5.
    for (int i = 0; i < 5; i++) begin wr_en[1] = 1; wr_data[1] = 8'h20 + 8'(i); step(); end
    idle();
    for (int i = 0; i < 3; i++) begin rd_en[1] = 1; step(); end
    idle();
    for (int i = 0; i < 3; i++) begin wr_en[1] = 1; wr_data[1] = 8'h25 + 8'(i); step(); end
    idle();
    chk("k1 count 5", cnt[1], 5);
    for (int i = 0; i < 5; i++) begin
      rd_en[1] = 1; step();
      chk("k1 wrap order", rd_data[1], 8'h23 + 8'(i));
    end
    idle(); step();

    // Empty FIFO, simultaneous read+write: no bypass.
    wr_en[0] = 1; rd_en[0] = 1; wr_data[0] = 8'h55; step(); idle();
    chk("k0 udf", udf[0], 1);
    chk("k0 udf err", err[0], 1);
    chk("k0 udf cnt", cnt[0], 1);
    chk("k0 udf rv", rd_valid[0], 0);
    rd_en[0] = 1; step(); idle();
    chk("k0 read 55", rd_data[0], 8'h55);
    clr[0] = 1; step(); idle();
    for (int i = 0; i < 8; i++) begin wr_en[0] = 1; wr_data[0] = 8'h60 + 8'(i); step(); end
    wr_en[0] = 1; rd_en[0] = 1; wr_data[0] = 8'h77; step(); idle();
    chk("k0 full rdwr cnt", cnt[0], 8);
    chk("k0 full rdwr ovf", ovf[0], 0);
    chk("k0 full rdwr data", rd_data[0], 8'h60);

    // Asynchronous reset in the middle of a read burst.
    clr[0] = 1; step(); idle();
    for (int i = 0; i < 4; i++) begin wr_en[0] = 1; wr_data[0] = 8'h30 + 8'(i); step(); end
    idle(); rd_en[0] = 1; step();
    @(posedge CLK); #2;
    chk("k0 rv before rst", rd_valid[0], 1);
    RESET = 1'b0; #1;
    idle();
    chk("async rst cnt", cnt[0], 0);
    chk("async rst rv", rd_valid[0], 0);
    chk("async rst data", rd_data[0], 0);
    step(); RESET = 1'b1;
    step();
    chk("post rst rv", rd_valid[0], 0);
    chk("post rst empty", f_empty[0], 1);
    chk("post rst ae", a_empty[0], 1);

    // Randomised traffic, alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 3000; c++) begin
      wp = ((c / 150) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      for (int k = 0; k < 3; k++) begin
        wr_en[k]   = ($urandom_range(0, 99) < wp);
        rd_en[k]   = ($urandom_range(0, 99) < rp);
        clr[k]     = ($urandom_range(0, 299) == 0);
        wr_data[k] = 8'($urandom);
      end
      step();
    end
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/circ_fifo_param.md
Name: circ_fifo_param

Overview:
- Parametrised circular-buffer FIFO; next generation of the team's fixed 8-entry circular buffer.
- Configurable data width, depth and almost-full/almost-empty thresholds.
- Optional overwrite-oldest mode, registered read data with a valid strobe, occupancy count, and overflow/underflow pulses feeding a sticky error flag.
- Sits between producer and consumer logic in the same clock domain; drop-in replacement for the existing buffer when WIDTH=8, DEPTH=8, OVERWRITE=0.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two, so pointer wrap is explicit).
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.
- OVERWRITE, 0, 0 = drop write when full; 1 = write when full replaces oldest entry.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous reset, active-low.
- clear  input  1  synchronous flush; also clears error.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
- fifo_empty  output  1  count == 0.
- fifo_full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  one-cycle pulse: write hit a full FIFO.
- underflow  output  1  one-cycle pulse: read hit an empty FIFO.
- error  output  1  sticky; set by overflow (OVERWRITE=0 only) or underflow.

Behaviour:
Reset (RESET=0, asynchronous, any time):
- wr_ptr=rd_ptr=count=0.
- rd_data=0, rd_valid=0, overflow=underflow=error=0.
- Storage contents are don't-care.
- Mid-operation reset abandons in-flight reads; rd_valid=0 on the first edge after release.

Pointers and status flags:
- Pointers run 0..DEPTH-1; increment from DEPTH-1 wraps to 0.
- fifo_empty, fifo_full, almost_full and almost_empty are combinational from registered count.

Clear (priority over all requests):
- clear=1 at an edge sets pointers and count to 0, rd_valid=0 and error=0; rd_data holds its value.
- wr_en/rd_en in the same cycle are ignored and raise no overflow/underflow.

Read:
- Accepted when rd_en && !fifo_empty.
- mem[rd_ptr] is registered into rd_data at that edge; rd_valid=1 for the following cycle (1-cycle latency); rd_ptr advances.
- rd_en && fifo_empty: no state change, underflow pulse, error set; rd_data holds, rd_valid=0.

Write:
- Accepted when wr_en && !fifo_full: mem[wr_ptr]<=wr_data, wr_ptr advances.

Simultaneous rd_en and wr_en:
- Non-empty: both accepted, count unchanged. When full this includes the write; no overflow.
- Empty: write accepted, read rejected with underflow. No write-to-read bypass.

Write when full, no accepted read:
- OVERWRITE=0: write discarded, overflow pulse, error set.
- OVERWRITE=1: oldest entry replaced (mem[wr_ptr]<=wr_data); wr_ptr and rd_ptr both advance; count stays DEPTH; overflow pulses; error not set.

Count and pulses:
- count += accepted_wr - accepted_rd, except the OVERWRITE=1 full case above.
- overflow/underflow are single-cycle and registered, asserted the cycle after the offending request.
- error stays high until clear or reset.

Test Plan:
- WIDTH=8, DEPTH=8: write 0x10..0x17 -> fifo_full=1, count=8, almost_full=1 after 7th write. Read 8 -> rd_data 0x10..0x17 in order, each 1 cycle after rd_en with rd_valid; then fifo_empty=1.
- DEPTH=5 wrap: write 5, read 3, write 3 -> count=5; read 5 yields correct order across pointer wrap 4->0.
- Full FIFO, OVERWRITE=0, write 0xAA -> overflow one cycle, error=1, count=8, 0xAA never read. Then clear -> error=0, count=0, fifo_empty=1.
- Full FIFO holding 0..7, OVERWRITE=1, write 0xEE -> count=8, error=0, overflow pulse. Reads return 1..7, then 0xEE.
- Empty FIFO, rd_en && wr_en with 0x55 -> underflow, error=1, count=1, rd_valid=0. Next read returns 0x55. Full FIFO, rd_en && wr_en -> count stays 8, no flags.
- Assert RESET low mid-burst (count=4) -> all outputs 0 immediately (asynchronous); after release, fifo_empty=1 and almost_empty=1.
